fx_noise_gate: RTL and testbench
================================

Name: fx_noise_gate

Overview:
Stereo downward expander / noise gate that sits in the same effects chain as fx_compressor and is its dynamic-range complement. The compressor reduces gain above threshold; this block cuts gain below threshold. The gate opens when the stereo peak reaches the threshold, holds, then releases. All gain changes follow an attack/hold/release state machine that advances only on sample_en. The audio interface and the parameter register format match the other fx_* blocks, so the gate drops into the chain unchanged.

Parameters:
DATA_W, 16, audio sample width (signed two's complement)
PARAM_W, 8, width of each fx_* control parameter
GAIN_FLOOR, 0, closed-state gain (0..32768, unity = 32768)
HOLD_SCALE, 4, hold length is fx_hold << HOLD_SCALE samples

Ports:
clk  input  1  system clock
reset_n  input  1  reset; asynchronous assert, active-low
sample_en  input  1  one-cycle strobe per audio sample
audio_in  input  signed [1:0][DATA_W-1:0]  stereo input, index 0 = L, index 1 = R
audio_out  output  signed [1:0][DATA_W-1:0]  stereo gated output
fx_threshold  input  PARAM_W  open threshold; 0 = gate bypassed
fx_attack  input  PARAM_W  attack rate
fx_hold  input  PARAM_W  hold duration
fx_release  input  PARAM_W  release rate
gate_open  output  1  high in OPEN or HOLD
gain  output  16  current gain, unsigned, unity = 0x8000

Behaviour:
- Clocking and reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset values:
  - audio_out = 0, gain = GAIN_FLOOR, gate_open = 0
  - state = CLOSED, hold_cnt = 0
- Reset asserted mid-operation clears all of the above immediately, with no clock required.
- Updates: every register changes only in a cycle where sample_en = 1. Otherwise all registers hold.
- Peak detection:
  - abs(x) saturates, so abs(-32768) = 32767.
  - peak = max(abs(L), abs(R)).
- Thresholds:
  - thr_open = fx_threshold * 128 (0..32640).
  - thr_close = thr_open >> 1 (hysteresis).
  - Comparisons are unsigned on 16 bits.
- Data path:
  - On sample_en: audio_out[c] <= (audio_in[c] * {1'b0, gain}) >>> 15, using the pre-update gain.
  - The product is 33 bits signed; the result fits in DATA_W, but saturate anyway.
  - gain = 0x8000 gives an exact passthrough.
  - Data latency is 1 clk after sample_en. Gain latency is 1 sample.
- Step sizes:
  - atk_step = (fx_attack + 1) << 4
  - rel_step = (fx_release + 1) << 2
- Gain arithmetic is 17-bit internally, clamped to [GAIN_FLOOR, 0x8000].
- State machine (evaluated on sample_en, all transitions mutually exclusive):
  - Bypass: fx_threshold == 0 forces state OPEN and gain 0x8000, overriding everything below.
  - CLOSED: gain = GAIN_FLOOR. If peak >= thr_open, go to ATTACK.
  - ATTACK: gain += atk_step. If the sum >= 0x8000, set gain = 0x8000 and go to OPEN. A peak drop during ATTACK is ignored.
  - OPEN: gain = 0x8000. If peak < thr_close, load hold_cnt = fx_hold << HOLD_SCALE and go to HOLD.
  - HOLD:
    - If peak >= thr_open, go back to OPEN.
    - Else if hold_cnt == 0, go to RELEASE.
    - Else hold_cnt -= 1.
    - fx_hold = 0 therefore passes through HOLD for exactly 1 sample.
  - RELEASE:
    - If peak >= thr_open, go to ATTACK, starting from the current gain.
    - Else gain -= rel_step. If the result <= GAIN_FLOOR, set gain = GAIN_FLOOR and go to CLOSED.
- Parameter changes take effect at the next sample_en. hold_cnt is latched only when HOLD is entered.
- An illegal state encoding recovers to CLOSED.

Decomposition:
- Shared package fx_pkg holds:
  - GAIN_UNITY = 17'h08000
  - enum gate_state_e {CLOSED, ATTACK, OPEN, HOLD, RELEASE}
  - function sat_abs()
  - function sat_mul_q15()
- Sub-module fx_peak_detect: purely combinational stereo sat-abs and max, reusable by fx_compressor.

Test Plan:
- Bypass: fx_threshold = 0, 1 kHz sine at amplitude 10000 on both channels → audio_out equals audio_in exactly 1 clk after each sample_en; gain = 0x8000 throughout.
- Gate closed: fx_threshold = 64 (thr_open 8192), DC 2000 after reset → audio_out = 0 and state CLOSED for 50 samples; GAIN_FLOOR = 0.
- Attack: fx_attack = 255 (step 4096), step DC 15000 → gain goes 0x1000, 0x2000, … and reaches 0x8000 on the 8th sample_en; output 7500 while gain = 0x4000; output 15000 once OPEN; gate_open = 1.
- Hold/release:
  - Setup: fx_hold = 1 (16 samples), fx_release = 255 (step 1024). From OPEN, drop input to 0.
  - Expected: HOLD for 17 sample_en, then RELEASE for 32 sample_en, gain 0x8000 → 0, then CLOSED with gate_open = 0.
  - Retrigger: DC 15000 applied mid-release → ATTACK starting from the current gain.
- Hysteresis: while OPEN, DC 6000 (above thr_close 4096) → stays OPEN; from CLOSED, DC 6000 → stays CLOSED.
- Extremes and reset:
  - Gate OPEN, inputs ±32768/32767 → outputs identical, no wrap.
  - L = 0, R = -32768 opens the gate (peak 32767).
  - reset_n deasserted mid-ATTACK without a clock edge → outputs go to 0 and state to CLOSED immediately.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared types and arithmetic helpers for the fx_* effects chain.
// Sample helpers work on FX_DATA_W-bit signed audio; gains are Q1.15, unity = 0x8000.
package fx_pkg;

  localparam int          FX_DATA_W  = 16;
  localparam logic [16:0] GAIN_UNITY = 17'h08000;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_e;

  // Saturating magnitude: the most negative code maps to the most positive one.
  function automatic logic [FX_DATA_W-1:0] sat_abs(input logic signed [FX_DATA_W-1:0] x);
    logic [FX_DATA_W-1:0] r;
    if (x == {1'b1, {(FX_DATA_W-1){1'b0}}}) begin
      r = {1'b0, {(FX_DATA_W-1){1'b1}}};
    end else if (x[FX_DATA_W-1]) begin
      r = FX_DATA_W'(-x);
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Signed sample times unsigned Q1.15 gain, arithmetic shift back, saturated to the sample range.
  function automatic logic signed [FX_DATA_W-1:0] sat_mul_q15(
    input logic signed [FX_DATA_W-1:0] x,
    input logic        [15:0]          g
  );
    logic signed [FX_DATA_W+16:0] xe;
    logic signed [FX_DATA_W+16:0] ge;
    logic signed [FX_DATA_W+16:0] prod;
    logic signed [FX_DATA_W+16:0] shr;
    logic signed [FX_DATA_W+16:0] hi;
    logic signed [FX_DATA_W+16:0] lo;
    logic signed [FX_DATA_W-1:0]  r;
    xe   = {{17{x[FX_DATA_W-1]}}, x};
    ge   = {{(FX_DATA_W+1){1'b0}}, g};
    hi   = {{18{1'b0}}, {(FX_DATA_W-1){1'b1}}};
    lo   = {{18{1'b1}}, {(FX_DATA_W-1){1'b0}}};
    prod = xe * ge;
    shr  = prod >>> 15;
    if (shr > hi) begin
      r = hi[FX_DATA_W-1:0];
    end else if (shr < lo) begin
      r = lo[FX_DATA_W-1:0];
    end else begin
      r = shr[FX_DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fx_peak_detect.sv
// Combinational stereo peak: max of the saturated magnitudes of L and R.
module fx_peak_detect
  import fx_pkg::*;
#(
  parameter int DATA_W = FX_DATA_W
) (
  input  logic signed [1:0][DATA_W-1:0] audio_in,
  output logic        [DATA_W-1:0]      peak
);

  logic [DATA_W-1:0] abs_l;
  logic [DATA_W-1:0] abs_r;

  assign abs_l = sat_abs(audio_in[0]);
  assign abs_r = sat_abs(audio_in[1]);
  assign peak  = (abs_l >= abs_r) ? abs_l : abs_r;

endmodule

// File: rtl/fx_noise_gate.sv
// Stereo noise gate / downward expander: CLOSED -> ATTACK -> OPEN -> HOLD -> RELEASE,
// with gain ramps and output multiply advancing only on sample_en.
module fx_noise_gate
  import fx_pkg::*;
#(
  parameter int DATA_W     = FX_DATA_W,
  parameter int PARAM_W    = 8,
  parameter int GAIN_FLOOR = 0,
  parameter int HOLD_SCALE = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_en,
  input  logic signed [1:0][DATA_W-1:0] audio_in,
  output logic signed [1:0][DATA_W-1:0] audio_out,
  input  logic        [PARAM_W-1:0]     fx_threshold,
  input  logic        [PARAM_W-1:0]     fx_attack,
  input  logic        [PARAM_W-1:0]     fx_hold,
  input  logic        [PARAM_W-1:0]     fx_release,
  output logic                          gate_open,
  output logic        [15:0]            gain
);

  localparam int          HOLD_W  = PARAM_W + HOLD_SCALE;
  localparam logic [15:0] UNITY16 = 16'(GAIN_UNITY);
  localparam logic [15:0] FLOOR16 = 16'(GAIN_FLOOR);
  localparam logic [16:0] FLOOR17 = 17'(GAIN_FLOOR);

  gate_state_e                   state_q, state_d;
  logic [15:0]                   gain_q, gain_d;
  logic [HOLD_W-1:0]             hold_cnt_q, hold_cnt_d;
  logic signed [1:0][DATA_W-1:0] audio_out_q, audio_out_d;

  logic [DATA_W-1:0] peak;
  logic [15:0]       thr_open;
  logic [15:0]       thr_close;
  logic [16:0]       atk_step;
  logic [16:0]       rel_step;
  logic [16:0]       gain17;
  logic [16:0]       atk_sum;
  logic [HOLD_W-1:0] hold_load;
  logic              bypass;
  logic              above_open;
  logic              below_close;

  fx_peak_detect #(
    .DATA_W(DATA_W)
  ) u_peak (
    .audio_in(audio_in),
    .peak    (peak)
  );

  assign thr_open    = 16'({fx_threshold, 7'b0});
  assign thr_close   = thr_open >> 1;
  assign atk_step    = (17'(fx_attack) + 17'd1) << 4;
  assign rel_step    = (17'(fx_release) + 17'd1) << 2;
  assign hold_load   = HOLD_W'(fx_hold) << HOLD_SCALE;
  assign bypass      = (fx_threshold == '0);
  assign above_open  = (16'(peak) >= thr_open);
  assign below_close = (16'(peak) < thr_close);
  assign gain17      = {1'b0, gain_q};
  assign atk_sum     = gain17 + atk_step;

  always_comb begin
    // NOTE: every _d starts at its current _q so paths that skip an assignment cannot infer a latch.
    state_d     = state_q;
    gain_d      = gain_q;
    hold_cnt_d  = hold_cnt_q;
    audio_out_d = audio_out_q;

    if (sample_en) begin
      // Output uses the gain held before this sample's state update.
      for (int c = 0; c < 2; c++) begin
        audio_out_d[c] = sat_mul_q15(audio_in[c], gain_q);
      end

      if (bypass) begin
        state_d = OPEN;
        gain_d  = UNITY16;
      end else begin
        case (state_q)
          CLOSED: begin
            gain_d = FLOOR16;
            if (above_open) state_d = ATTACK;
          end
          ATTACK: begin
            if (atk_sum >= GAIN_UNITY) begin
              gain_d  = UNITY16;
              state_d = OPEN;
            end else begin
              gain_d = atk_sum[15:0];
            end
          end
          OPEN: begin
            gain_d = UNITY16;
            if (below_close) begin
              hold_cnt_d = hold_load;
              state_d    = HOLD;
            end
          end
          HOLD: begin
            if (above_open) begin
              state_d = OPEN;
            end else if (hold_cnt_q == '0) begin
              state_d = RELEASE;
            end else begin
              hold_cnt_d = hold_cnt_q - 1'b1;
            end
          end
          RELEASE: begin
            if (above_open) begin
              state_d = ATTACK;
            end else if (gain17 <= FLOOR17 + rel_step) begin
              gain_d  = FLOOR16;
              state_d = CLOSED;
            end else begin
              gain_d = 16'(gain17 - rel_step);
            end
          end
          default: begin
            state_d = CLOSED;
            gain_d  = FLOOR16;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLOSED;
      gain_q      <= FLOOR16;
      hold_cnt_q  <= '0;
      audio_out_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples its _d from the same pre-edge values.
      state_q     <= state_d;
      gain_q      <= gain_d;
      hold_cnt_q  <= hold_cnt_d;
      audio_out_q <= audio_out_d;
    end
  end

  assign audio_out = audio_out_q;
  assign gain      = gain_q;
  assign gate_open = (state_q == OPEN) || (state_q == HOLD);

endmodule

// File: tb/tb_fx_noise_gate.sv
// Directed self-checking bench for fx_noise_gate (GAIN_FLOOR = 0, HOLD_SCALE = 4).
module tb_fx_noise_gate;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b1;
  logic                     sample_en = 1'b0;
  logic signed [1:0][15:0]  audio_in = '0;
  logic signed [1:0][15:0]  audio_out;
  logic        [7:0]        fx_threshold = 8'd0;
  logic        [7:0]        fx_attack = 8'd255;
  logic        [7:0]        fx_hold = 8'd1;
  logic        [7:0]        fx_release = 8'd255;
  logic                     gate_open;
  logic        [15:0]       gain;

  int n_checks = 0;
  int n_pass   = 0;
  int sine_tbl [8] = '{0, 7071, 10000, 7071, 0, -7071, -10000, -7071};

  fx_noise_gate #(
    .DATA_W    (16),
    .PARAM_W   (8),
    .GAIN_FLOOR(0),
    .HOLD_SCALE(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_en   (sample_en),
    .audio_in    (audio_in),
    .audio_out   (audio_out),
    .fx_threshold(fx_threshold),
    .fx_attack   (fx_attack),
    .fx_hold     (fx_hold),
    .fx_release  (fx_release),
    .gate_open   (gate_open),
    .gain        (gain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] s16(input int v);
    logic [15:0] t;
    t = 16'(v);
    return {16'b0, t};
  endfunction

  // One strobe; returns at the falling edge after the capturing rising edge.
  task automatic sample(input int l, input int r);
    @(negedge clk);
    audio_in[0] = 16'(l);
    audio_in[1] = 16'(r);
    sample_en   = 1'b1;
    @(negedge clk);
    sample_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int prev_gain;

    // Asynchronous reset before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_l", s16(audio_out[0]), 32'h0);
    check("rst_out_r", s16(audio_out[1]), 32'h0);
    check("rst_gain",  32'(gain), 32'h0);
    check("rst_open",  32'(gate_open), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Bypass: first strobe still uses the reset gain, after that exact passthrough
    fx_threshold = 8'd0;
    sample(0, 0);
    check("byp_gain0", 32'(gain), 32'h8000);
    check("byp_open0", 32'(gate_open), 32'h1);
    for (int i = 0; i < 16; i++) begin
      sample(sine_tbl[i % 8], sine_tbl[(i + 4) % 8]);
      check("byp_out_l", s16(audio_out[0]), s16(sine_tbl[i % 8]));
      check("byp_out_r", s16(audio_out[1]), s16(sine_tbl[(i + 4) % 8]));
      check("byp_gain",  32'(gain), 32'h8000);
    end
    // Registers hold without sample_en
    audio_in[0] = 16'sd1234;
    audio_in[1] = 16'sd4321;
    repeat (3) @(negedge clk);
    check("idle_hold_l", s16(audio_out[0]), s16(-7071));
    check("idle_hold_r", s16(audio_out[1]), s16(7071));

    // Gate closed with DC below threshold
    pulse_reset();
    fx_threshold = 8'd64;
    fx_attack    = 8'd255;
    fx_hold      = 8'd1;
    fx_release   = 8'd255;
    for (int i = 0; i < 50; i++) begin
      sample(2000, 2000);
      check("cls_out",  s16(audio_out[0]), 32'h0);
      check("cls_open", 32'(gate_open), 32'h0);
    end
    check("cls_gain", 32'(gain), 32'h0);
    // Hysteresis from CLOSED: above thr_close but below thr_open
    for (int i = 0; i < 5; i++) begin
      sample(6000, -6000);
      check("hys_cls_gain", 32'(gain), 32'h0);
      check("hys_cls_open", 32'(gate_open), 32'h0);
    end

    // Attack: CLOSED->ATTACK on the first strobe, then 4096 per strobe
    sample(15000, 15000);
    check("atk_enter_gain", 32'(gain), 32'h0);
    check("atk_enter_open", 32'(gate_open), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      sample(15000, 15000);
      check("atk_gain", 32'(gain), 32'(k * 4096));
      check("atk_out",  s16(audio_out[0]), s16(1875 * (k - 1)));
      check("atk_open", 32'(gate_open), (k == 8) ? 32'h1 : 32'h0);
    end
    sample(15000, -15000);
    check("open_out_l", s16(audio_out[0]), s16(15000));
    check("open_out_r", s16(audio_out[1]), s16(-15000));

    // Hysteresis from OPEN
    for (int i = 0; i < 5; i++) begin
      sample(6000, 6000);
      check("hys_open",     32'(gate_open), 32'h1);
      check("hys_open_out", s16(audio_out[0]), s16(6000));
    end

    // Extremes pass without wrap
    sample(-32768, 32767);
    check("ext1_l", s16(audio_out[0]), s16(-32768));
    check("ext1_r", s16(audio_out[1]), s16(32767));
    sample(32767, -32768);
    check("ext2_l", s16(audio_out[0]), s16(32767));
    check("ext2_r", s16(audio_out[1]), s16(-32768));

    // Hold (fx_hold=1 -> 16) then release (step 1024), DC 1000 below thr_close
    sample(1000, 1000);
    check("hold_enter_open", 32'(gate_open), 32'h1);
    for (int i = 0; i < 16; i++) begin
      sample(1000, 1000);
      check("hold_open", 32'(gate_open), 32'h1);
      check("hold_out",  s16(audio_out[0]), s16(1000));
    end
    sample(1000, 1000);
    check("rel_enter_open", 32'(gate_open), 32'h0);
    check("rel_enter_gain", 32'(gain), 32'h8000);
    for (int j = 1; j <= 32; j++) begin
      prev_gain = 32768 - 1024 * (j - 1);
      sample(1000, 1000);
      check("rel_gain", 32'(gain), 32'(32768 - 1024 * j));
      check("rel_out",  s16(audio_out[0]), s16((1000 * prev_gain) >>> 15));
      check("rel_open", 32'(gate_open), 32'h0);
    end
    sample(1000, 1000);
    check("closed_gain", 32'(gain), 32'h0);
    check("closed_out",  s16(audio_out[0]), s16(0));

    // L=0, R=-32768 opens the gate via saturated peak
    sample(0, -32768);
    check("neg_atk_gain", 32'(gain), 32'h0);
    for (int k = 1; k <= 8; k++) sample(0, -32768);
    check("neg_open",  32'(gate_open), 32'h1);
    check("neg_gain",  32'(gain), 32'h8000);
    sample(0, -32768);
    check("neg_out_l", s16(audio_out[0]), s16(0));
    check("neg_out_r", s16(audio_out[1]), s16(-32768));

    // fx_hold=0: exactly one strobe in HOLD, then release and retrigger
    fx_hold = 8'd0;
    sample(0, 0);
    check("h0_hold_open", 32'(gate_open), 32'h1);
    sample(0, 0);
    check("h0_rel_open", 32'(gate_open), 32'h0);
    check("h0_rel_gain", 32'(gain), 32'h8000);
    for (int k = 0; k < 10; k++) sample(0, 0);
    check("retrig_pre_gain", 32'(gain), 32'h5800);
    sample(15000, 15000);
    check("retrig_gain0", 32'(gain), 32'h5800);
    check("retrig_open0", 32'(gate_open), 32'h0);
    sample(15000, 15000);
    check("retrig_gain1", 32'(gain), 32'h6800);
    sample(15000, 15000);
    check("retrig_gain2", 32'(gain), 32'h7800);
    sample(15000, 15000);
    check("retrig_gain3", 32'(gain), 32'h8000);
    check("retrig_open3", 32'(gate_open), 32'h1);

    // Reset mid-ATTACK without a clock edge
    pulse_reset();
    sample(15000, 15000);
    sample(15000, 15000);
    sample(15000, 15000);
    check("mid_atk_gain", 32'(gain), 32'h2000);
    check("mid_atk_out",  s16(audio_out[0]), s16(1875));
    #1 reset_n = 1'b0;
    #1;
    check("async_out_l", s16(audio_out[0]), 32'h0);
    check("async_out_r", s16(audio_out[1]), 32'h0);
    check("async_gain",  32'(gain), 32'h0);
    check("async_open",  32'(gate_open), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    sample(15000, 15000);
    check("post_rst_gain0", 32'(gain), 32'h0);
    sample(15000, 15000);
    check("post_rst_gain1", 32'(gain), 32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
